// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_pkg
//  Description : Shared CPU definitions used by the iterative shifter.
//                - Shift opcodes. The main decoder uses the same values.
//                - Shift-sequencer state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_seq_pkg;

  // Default datapath geometry. The shift amount is the shamt field that the
  // zero-extender widens.
  localparam int unsigned CPU_XLEN = 32;
  localparam int unsigned CPU_SHW  = 5;

  // Shift opcode, as encoded in the OP field of a shift request.
  typedef logic [1:0] sh_op_t;

  localparam sh_op_t SH_SLL = 2'b00;  // logical left
  localparam sh_op_t SH_SRL = 2'b01;  // logical right
  localparam sh_op_t SH_SRA = 2'b10;  // arithmetic right
  localparam sh_op_t SH_ROR = 2'b11;  // rotate right

  // Sequencer state encodings. Kept as plain constants so that older
  // netlists and decoders that compare raw state bits stay compatible.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

endpackage : shift_seq_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
//  Module      : shift_step
//  Description : Combinational single-position shifter. Computes the value of
//                the accumulator after one step of SLL, SRL, SRA or ROR.
//  Ports       : acc_i  in  WIDTH  current accumulator value
//                op_i   in  2      shift opcode (SH_SLL/SH_SRL/SH_SRA/SH_ROR)
//                acc_o  out WIDTH  accumulator value after one step
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_XLEN
) (
  input  logic [WIDTH-1:0] acc_i,
  input  sh_op_t           op_i,
  output logic [WIDTH-1:0] acc_o
);

  always_comb begin
    acc_o = acc_i;
    case (op_i)
      SH_SLL:  acc_o = {acc_i[WIDTH-2:0], 1'b0};
      SH_SRL:  acc_o = {1'b0, acc_i[WIDTH-1:1]};
      // The sign bit is replicated, so after WIDTH-1 steps the whole word
      // holds the original sign.
      SH_SRA:  acc_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
      SH_ROR:  acc_o = {acc_i[0], acc_i[WIDTH-1:1]};
      default: acc_o = acc_i;
    endcase
  end

endmodule : shift_step
`default_nettype wire

// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq
//  Description : Iterative shift unit. Performs SLL/SRL/SRA/ROR on a WIDTH-bit
//                operand one bit position per clock. It is an area-saving
//                alternative to a combinational barrel shifter.
//  Ports       : CLK    in  1      clock, rising edge
//                RST    in  1      asynchronous active-high reset
//                START  in  1      request strobe (IDLE or FIN only)
//                OP     in  2      00 SLL, 01 SRL, 10 SRA, 11 ROR
//                SHAMT  in  SHW    shift amount 0..WIDTH-1
//                DIN    in  WIDTH  operand
//                BUSY   out 1      high while shifting
//                DONE   out 1      one-cycle result-valid pulse
//                DOUT   out WIDTH  result register (toggles while BUSY)
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_XLEN,
  parameter int unsigned SHW   = CPU_SHW     // must equal log2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [SHW-1:0]   SHAMT,
  input  logic [WIDTH-1:0] DIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DOUT
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;
  sh_op_t           op_q,    op_d;

  logic [WIDTH-1:0] step_acc;
  logic             accept;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i (acc_q),
    .op_i  (op_q),
    .acc_o (step_acc)
  );

  // FIN also accepts a request. This lets START held high chain operations
  // with no idle bubble between them.
  assign accept = START && ((state_q == ST_IDLE) || (state_q == ST_FIN));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (accept) begin
          acc_d   = DIN;
          cnt_d   = SHAMT;
          op_d    = OP;
          // A zero amount still passes through FIN, so DONE pulses one edge
          // after the accept.
          state_d = (SHAMT == '0) ? ST_FIN : ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        // START is ignored here because the unit does not queue requests.
        acc_d = step_acc;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = ST_FIN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= SH_SLL;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // All outputs are decoded from registers only. No input-to-output path.
  assign BUSY = (state_q == ST_SHIFT);
  assign DONE = (state_q == ST_FIN);
  assign DOUT = acc_q;

endmodule : shift_seq
`default_nettype wire

// File: doc/shift_seq.md
# shift_seq

Iterative shift unit for the CPU datapath. Accepts a 32-bit operand and a 5-bit shift amount, the same `shamt` field the zero-extender widens, and performs SLL, SRL, SRA or ROR one bit position per clock. It replaces a combinational barrel shifter in area-constrained builds. Control stalls the pipeline while `BUSY` is high and writes `DOUT` back when `DONE` pulses.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width.
- `SHW`, 5, shift-amount width; must equal log2(`WIDTH`).

Ports:
- `CLK`  in  1  clock; all state changes on rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `START`  in  1  request strobe; sampled only when the unit can accept.
- `OP`  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- `SHAMT`  in  `SHW`  shift amount, unsigned 0..31.
- `DIN`  in  `WIDTH`  operand.
- `BUSY`  out  1  high while in SHIFT state.
- `DONE`  out  1  one-cycle pulse; result valid.
- `DOUT`  out  `WIDTH`  result register.

## Operation
- State machine has three states: IDLE, SHIFT, FIN. `BUSY` = (state==SHIFT). `DONE` = (state==FIN).
- Internal registers: `acc[WIDTH-1:0]`, `cnt[SHW-1:0]`, `op_q[1:0]`. `DOUT` is driven directly from `acc`.
- Accept condition: `START`=1 and state is IDLE or FIN. On accept, `acc`<=`DIN`, `cnt`<=`SHAMT`, `op_q`<=`OP`.
  - If `SHAMT`==0, next state is FIN.
  - Otherwise next state is SHIFT.
- SHIFT, every edge:
  - `acc` is shifted by one position per `op_q`:
    - SLL: `{acc[30:0],0}`.
    - SRL: `{0,acc[31:1]}`.
    - SRA: `{acc[31],acc[31:1]}`.
    - ROR: `{acc[0],acc[31:1]}`.
  - `cnt`<=`cnt`-1.
  - If `cnt`==1, next state is FIN.
  - `START` is ignored in SHIFT; there is no queueing.
- FIN lasts exactly one cycle. It goes to IDLE, or takes the accept path when `START`=1, giving back-to-back operation with no bubble.
- IDLE holds all registers. `DOUT` holds the last result until the next accept.
- `OP`, `SHAMT` and `DIN` are don't-care except at the accept edge. Changing them mid-operation has no effect.
- Arithmetic: no result bit depends on `SHAMT` ≥ `WIDTH`, because `SHW` bits cap the amount at 31. SRA with `SHAMT`=31 yields all-sign.
- Reset, asynchronous and valid at any time including mid-SHIFT: state=IDLE, `acc`=0, `cnt`=0, `op_q`=0. Outputs become `BUSY`=0, `DONE`=0, `DOUT`=0. The in-flight operation is discarded and there is no `DONE` pulse for it.

## Timing
- Latency is measured from the accept edge to the edge after which `DONE` is high. It is `SHAMT`+1 edges; `SHAMT`=0 gives 1 edge.
- Throughput is one operation per `SHAMT`+1 cycles when `START` is held high continuously.
- `BUSY` rises the cycle after accept when `SHAMT`≠0. It falls in the same cycle `DONE` rises.
- `DONE` and `DOUT` are registered outputs; there is no combinational path from inputs to outputs.
- `DOUT` toggles during SHIFT. Consumers must sample it only when `DONE`=1, or later in IDLE.

## Structure
- The shared CPU definitions package holds:
  - Shift opcode constants `SH_SLL`=2'b00, `SH_SRL`=2'b01, `SH_SRA`=2'b10, `SH_ROR`=2'b11.
  - State encodings `ST_IDLE`, `ST_SHIFT`, `ST_FIN`.
- The same opcode constants are used by the main decoder.
- One sub-module, `shift_step`: a combinational single-bit shifter (`acc`, `op` → next `acc`). It is instantiated once and reused by the bench as a reference model.
- Top level `shift_seq` contains only the FSM, the counter and the registers.

## Test plan
- Reset mid-SHIFT:
  - Stimulus: `DIN`=0xF0000001, SLL, `SHAMT`=8; assert `RST` 3 cycles after accept.
  - Response: outputs go to 0 immediately, and `BUSY`/`DONE`/`DOUT` stay 0 until the next accept.
- Zero shift: `DIN`=0xDEADBEEF, `SHAMT`=0, SRA → `DONE` 1 edge after accept, `DOUT`=0xDEADBEEF, `BUSY` never high.
- SRA full: `DIN`=0x80000000, `SHAMT`=31 → `DONE` after 32 edges, `DOUT`=0xFFFFFFFF. Same operands with SRL → `DOUT`=0x00000001.
- ROR and SLL:
  - ROR: `DIN`=0x00000001, `SHAMT`=4 → `DOUT`=0x10000000 after 5 edges.
  - SLL: `DIN`=0x00000003, `SHAMT`=30 → `DOUT`=0xC0000000.
- Back-to-back and ignored requests:
  - Stimulus: `START` held high across a 2-amount SLL of 0x1 followed by a 3-amount SRL of 0x80.
  - Response: second accept occurs in FIN, with no idle cycle. `DONE` pulses at edges 3 and 7, with `DOUT`=0x4 then 0x10.
  - `START` pulses during SHIFT are ignored.
